// File: rtl/solver_control_mc.sv
// Sequencer for the multi-limb fixed-point Mandelbrot datapath: walks limb-pair partial
// products column by column, drains the pipeline, checks divergence, hands off the result.
module solver_control_mc #(
  parameter int unsigned LIMB_INDEX_BITS = 6,
  parameter int unsigned ITER_BITS       = 16,
  parameter int unsigned FLUSH_WAIT      = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       wr_real_en,
  input  logic                       wr_imag_en,
  input  logic [LIMB_INDEX_BITS-1:0] wr_ind,
  input  logic                       wr_num_limbs_en,
  input  logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
  input  logic                       wr_iter_lim_en,
  input  logic [ITER_BITS-1:0]       iter_lim_data,
  input  logic                       start,
  input  logic                       abort,
  output logic                       cre_wr_en,
  output logic                       cim_wr_en,
  output logic [LIMB_INDEX_BITS-1:0] c_limb_ind,
  output logic [LIMB_INDEX_BITS-1:0] zre_rd_ind,
  output logic [LIMB_INDEX_BITS-1:0] zim_rd_ind,
  output logic                       phase,
  output logic                       square_term,
  output logic                       col_first,
  output logic                       col_last,
  output logic                       z_wr_en,
  output logic [LIMB_INDEX_BITS-1:0] z_wr_ind,
  output logic                       clear_lsd,
  output logic                       first_iter,
  input  logic                       diverged,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ITER_BITS-1:0]       result_count,
  output logic                       result_escaped
);

  localparam int unsigned FlushBits = (FLUSH_WAIT > 0) ? $clog2(FLUSH_WAIT + 1) : 1;

  typedef enum logic [2:0] {StIdle, StIter, StFlush, StCheck, StDone} state_e;

  state_e                     state_q, state_d;
  logic [LIMB_INDEX_BITS-1:0] num_limbs_q, num_limbs_d;
  logic [ITER_BITS-1:0]       iter_limit_q, iter_limit_d;
  logic [ITER_BITS-1:0]       iter_count_q, iter_count_d;
  logic [LIMB_INDEX_BITS-1:0] k_q, k_d;
  logic [LIMB_INDEX_BITS-1:0] i_q, i_d;
  logic                       phase_q, phase_d;
  logic [FlushBits-1:0]       flush_q, flush_d;
  logic                       out_valid_q, out_valid_d;
  logic [ITER_BITS-1:0]       result_count_q, result_count_d;
  logic                       result_escaped_q, result_escaped_d;

  logic [LIMB_INDEX_BITS-1:0] k_minus_i;
  logic                       col_end;
  logic [ITER_BITS-1:0]       limit_m1;

  assign k_minus_i = k_q - i_q;
  assign col_end   = phase_q && (i_q == (k_q >> 1));
  // Modular: a limit of 0 runs 2^ITER_BITS iterations.
  assign limit_m1  = iter_limit_q - ITER_BITS'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      num_limbs_q      <= '0;
      iter_limit_q     <= '1;
      iter_count_q     <= '0;
      k_q              <= '0;
      i_q              <= '0;
      phase_q          <= 1'b0;
      flush_q          <= '0;
      out_valid_q      <= 1'b0;
      result_count_q   <= '0;
      result_escaped_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      num_limbs_q      <= num_limbs_d;
      iter_limit_q     <= iter_limit_d;
      iter_count_q     <= iter_count_d;
      k_q              <= k_d;
      i_q              <= i_d;
      phase_q          <= phase_d;
      flush_q          <= flush_d;
      out_valid_q      <= out_valid_d;
      result_count_q   <= result_count_d;
      result_escaped_q <= result_escaped_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    num_limbs_d      = num_limbs_q;
    iter_limit_d     = iter_limit_q;
    iter_count_d     = iter_count_q;
    k_d              = k_q;
    i_d              = i_q;
    phase_d          = phase_q;
    flush_d          = flush_q;
    out_valid_d      = out_valid_q;
    result_count_d   = result_count_q;
    result_escaped_d = result_escaped_q;

    case (state_q)
      StIdle: begin
        if (wr_num_limbs_en) num_limbs_d = num_limbs_data;
        if (wr_iter_lim_en)  iter_limit_d = iter_lim_data;
        if (start && (num_limbs_q != '0)) begin
          state_d      = StIter;
          iter_count_d = '0;
          k_d          = num_limbs_q - LIMB_INDEX_BITS'(1);
          i_d          = '0;
          phase_d      = 1'b0;
        end
      end
      StIter: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          phase_d = ~phase_q;
          if (col_end) begin
            i_d = '0;
            k_d = k_q - LIMB_INDEX_BITS'(1);
            if (k_q == '0) begin
              state_d = StFlush;
              flush_d = FlushBits'(FLUSH_WAIT);
            end
          end else if (phase_q) begin
            i_d = i_q + LIMB_INDEX_BITS'(1);
          end
        end
      end
      StFlush: begin
        if (abort) begin
          state_d = StIdle;
        end else if (flush_q == '0) begin
          state_d = StCheck;
        end else begin
          flush_d = flush_q - FlushBits'(1);
        end
      end
      StCheck: begin
        if (abort) begin
          state_d = StIdle;
        end else if (diverged && (iter_count_q != '0)) begin
          state_d          = StDone;
          out_valid_d      = 1'b1;
          result_count_d   = iter_count_q;
          result_escaped_d = 1'b1;
        end else if (iter_count_q == limit_m1) begin
          state_d          = StDone;
          out_valid_d      = 1'b1;
          result_count_d   = iter_count_q;
          result_escaped_d = 1'b0;
        end else begin
          state_d      = StIter;
          iter_count_d = iter_count_q + ITER_BITS'(1);
          k_d          = num_limbs_q - LIMB_INDEX_BITS'(1);
          i_d          = '0;
          phase_d      = 1'b0;
        end
      end
      StDone: begin
        if (abort || out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    cre_wr_en   = 1'b0;
    cim_wr_en   = 1'b0;
    c_limb_ind  = '0;
    zre_rd_ind  = '0;
    zim_rd_ind  = '0;
    phase       = 1'b0;
    square_term = 1'b0;
    col_first   = 1'b0;
    col_last    = 1'b0;
    z_wr_en     = 1'b0;
    z_wr_ind    = '0;
    clear_lsd   = 1'b0;
    first_iter  = 1'b0;

    case (state_q)
      StIdle: begin
        c_limb_ind = wr_ind;
        cre_wr_en  = wr_real_en;
        cim_wr_en  = wr_imag_en;
      end
      StIter: begin
        zre_rd_ind  = phase_q ? k_minus_i : i_q;
        zim_rd_ind  = phase_q ? i_q : k_minus_i;
        phase       = phase_q;
        square_term = (i_q == k_minus_i);
        col_first   = (i_q == '0) && !phase_q;
        col_last    = col_end;
        // An aborted column must not commit a partial result.
        z_wr_en     = col_end && !abort;
        z_wr_ind    = k_q;
        first_iter  = (iter_count_q == '0);
      end
      StCheck: clear_lsd = 1'b1;
      default: ;
    endcase
  end

  assign busy           = (state_q != StIdle);
  assign out_valid      = out_valid_q;
  assign result_count   = result_count_q;
  assign result_escaped = result_escaped_q;

endmodule
